pipelined_adder: RTL and testbench

//   Parametrised, pipelined add/subtract unit replacing the flat combinational adder tree.

---
 rtl/pipelined_adder.sv | 121 ++++++++++++
 tb/tb_pipelined_adder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract: one CHUNK-bit slice is resolved per stage, with the carry
// registered into the next stage. Operands ride along ahead of the carry; finished sum slices trail behind it.
module pipelined_adder #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);
    localparam int unsigned STAGES = WIDTH / CHUNK;
    localparam int unsigned LAST   = STAGES - 1;

    logic             advance;
    logic [WIDTH-1:0] b_eff;

    // Per-stage view of what feeds each stage: the live inputs for stage 0,
    // the previous stage's registers otherwise.
    logic [WIDTH-1:0] in_a      [STAGES];
    logic [WIDTH-1:0] in_b      [STAGES];
    logic             in_c      [STAGES];
    logic             in_v      [STAGES];
    logic [CHUNK:0]   slice_sum [STAGES];

    // word_a holds finished sum slices below the active slice and raw A above it,
    // so the last stage's word_a is the aligned result.
    logic [WIDTH-1:0] word_a_q  [STAGES];
    logic [WIDTH-1:0] word_a_d  [STAGES];
    logic [WIDTH-1:0] word_b_q  [STAGES];
    logic [WIDTH-1:0] word_b_d  [STAGES];
    logic             carry_q   [STAGES];
    logic             carry_d   [STAGES];
    logic             valid_q   [STAGES];
    logic             valid_d   [STAGES];
    logic             ovf_q;
    logic             ovf_d;

    assign advance   = !valid_q[LAST] || out_ready;
    assign in_ready  = advance;
    assign b_eff     = sub ? ~b : b;

    assign out_valid = valid_q[LAST];
    assign sum       = word_a_q[LAST];
    assign carry_out = carry_q[LAST];
    assign overflow  = ovf_q;

    always_comb begin
        in_a[0] = a;
        in_b[0] = b_eff;
        in_c[0] = sub;
        in_v[0] = in_valid;
        for (int unsigned k = 1; k < STAGES; k++) begin
            in_a[k] = word_a_q[k-1];
            in_b[k] = word_b_q[k-1];
            in_c[k] = carry_q[k-1];
            in_v[k] = valid_q[k-1];
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < STAGES; k++) begin
            slice_sum[k] = {1'b0, in_a[k][k*CHUNK +: CHUNK]}
                         + {1'b0, in_b[k][k*CHUNK +: CHUNK]}
                         + {{CHUNK{1'b0}}, in_c[k]};
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        for (int unsigned k = 0; k < STAGES; k++) begin
            word_a_d[k] = word_a_q[k];
            word_b_d[k] = word_b_q[k];
            carry_d[k]  = carry_q[k];
            valid_d[k]  = valid_q[k];
            if (advance) begin
                valid_d[k] = in_v[k];
                if (in_v[k]) begin
                    word_a_d[k]                   = in_a[k];
                    word_a_d[k][k*CHUNK +: CHUNK] = slice_sum[k][CHUNK-1:0];
                    word_b_d[k]                   = in_b[k];
                    carry_d[k]                    = slice_sum[k][CHUNK];
                end
            end
        end
        // Carry into the MSB is recovered from the MSB's own sum bit and operand bits.
        if (advance && in_v[LAST]) begin
            ovf_d = (in_a[LAST][WIDTH-1] ^ in_b[LAST][WIDTH-1] ^ slice_sum[LAST][CHUNK-1])
                  ^ slice_sum[LAST][CHUNK];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                word_a_q[k] <= '0;
                word_b_q[k] <= '0;
                carry_q[k]  <= 1'b0;
                valid_q[k]  <= 1'b0;
            end
            ovf_q <= 1'b0;
        end else begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                word_a_q[k] <= word_a_d[k];
                word_b_q[k] <= word_b_d[k];
                carry_q[k]  <= carry_d[k];
                valid_q[k]  <= valid_d[k];
            end
            ovf_q <= ovf_d;
        end
    end

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder: the driver pushes reference results on accept,
// and a negedge monitor compares every presented output against the queue head.
module tb_pipelined_adder;

    typedef struct packed {
        logic [31:0] s;
        logic        c;
        logic        o;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, sub, out_valid, out_ready, carry_out, overflow;
    logic [31:0] a, b, sum;

    logic        in_valid8, in_ready8, sub8, out_valid8, out_ready8, carry_out8, overflow8;
    logic [7:0]  a8, b8, sum8;

    logic        rdy_rand = 1'b0;
    exp_t        sbq[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] corners [4];

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .carry_out(carry_out), .overflow(overflow)
    );

    pipelined_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .sub(sub8), .out_valid(out_valid8), .out_ready(out_ready8),
        .sum(sum8), .carry_out(carry_out8), .overflow(overflow8)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    // Reference: plain integer arithmetic on 64-bit values.
    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic s);
        exp_t   r;
        longint ux, uy, sx, sy, full, sres;
        ux = longint'({32'd0, x});
        uy = longint'({32'd0, y});
        sx = $signed(x);
        sy = $signed(y);
        if (s) begin
            full = ux - uy;
            sres = sx - sy;
            r.c  = (ux >= uy);
        end else begin
            full = ux + uy;
            sres = sx + sy;
            r.c  = full[32];
        end
        r.s = full[31:0];
        r.o = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
        return r;
    endfunction

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rdy_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1) begin
            check("expected_pending", 64'(sbq.size() != 0), 64'd1);
            if (sbq.size() != 0) begin
                check("out_sum",   64'(sum),       64'(sbq[0].s));
                check("out_carry", 64'(carry_out), 64'(sbq[0].c));
                check("out_ovf",   64'(overflow),  64'(sbq[0].o));
                if (out_ready) void'(sbq.pop_front());
            end
        end
    end

    // Caller is just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [31:0] a_i, input logic [31:0] b_i, input logic s_i);
        bit acc;
        acc      = 1'b0;
        a        = a_i;
        b        = b_i;
        sub      = s_i;
        in_valid = 1'b1;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sbq.push_back(model(a_i, b_i, s_i));
                acc = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        check("accept", 64'(acc), 64'd1);
    endtask

    task automatic directed(input string nm, input logic [31:0] a_i, input logic [31:0] b_i,
                            input logic s_i, input logic [31:0] es, input logic ec,
                            input logic eo);
        int edges;
        bit seen;
        send(a_i, b_i, s_i);
        in_valid = 1'b0;
        edges    = 1;
        seen     = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
            else begin
                @(posedge clk);
                #1;
                edges++;
            end
        end
        check({nm, "_seen"},    64'(seen),      64'd1);
        check({nm, "_latency"}, 64'(edges),     64'd4);
        check({nm, "_sum"},     64'(sum),       64'(es));
        check({nm, "_carry"},   64'(carry_out), 64'(ec));
        check({nm, "_ovf"},     64'(overflow),  64'(eo));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 500 && sbq.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", 64'(sbq.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, required $finish before time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0] ra, rb;
        corners[0] = 32'hFFFF_FFFF;
        corners[1] = 32'h8000_0000;
        corners[2] = 32'h7FFF_FFFF;
        corners[3] = 32'h0000_0000;

        // 1: reset held with in_valid high
        rst_n      = 1'b0;
        in_valid   = 1'b1;
        a          = $urandom;
        b          = $urandom;
        sub        = 1'b1;
        in_valid8  = 1'b1;
        a8         = 8'hFF;
        b8         = 8'h01;
        sub8       = 1'b0;
        out_ready8 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid",  64'(out_valid),  64'd0);
        check("rst_sum",        64'(sum),        64'd0);
        check("rst_carry",      64'(carry_out),  64'd0);
        check("rst_ovf",        64'(overflow),   64'd0);
        check("rst_out_valid8", 64'(out_valid8), 64'd0);
        check("rst_sum8",       64'(sum8),       64'd0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_valid8 = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        repeat (6) @(posedge clk);
        #1;
        check("no_spurious", 64'(out_valid), 64'd0);

        // 2, 3: carry ripple and signed overflow corners
        directed("ripple",   32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        directed("sub_ovf",  32'h8000_0000, 32'h1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        directed("add_ovf",  32'h7FFF_FFFF, 32'h1, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        directed("borrow",   32'h0000_0000, 32'h1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);

        // 4: back-to-back random ops with random back-pressure
        rdy_rand = 1'b1;
        for (int i = 0; i < 64; i++) begin
            ra = ($urandom_range(0, 7) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
            rb = ($urandom_range(0, 7) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
            send(ra, rb, 1'($urandom_range(0, 1)));
        end
        in_valid = 1'b0;
        drain();
        rdy_rand = 1'b0;
        @(posedge clk);
        #1;

        // 5: reset with three ops in flight
        send($urandom, $urandom, 1'b0);
        send($urandom, $urandom, 1'b1);
        send($urandom, $urandom, 1'b0);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        check("pre_reset_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        sbq.delete();
        #1;
        check("async_drop_valid", 64'(out_valid), 64'd0);
        check("async_drop_sum",   64'(sum),       64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        directed("after_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("after_rst_idle", 64'(out_valid), 64'd0);

        // 6: single-stage instance
        a8        = 8'h7F;
        b8        = 8'h01;
        sub8      = 1'b0;
        in_valid8 = 1'b1;
        @(negedge clk);
        check("s1_in_ready", 64'(in_ready8), 64'd1);
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        @(negedge clk);
        check("s1_valid", 64'(out_valid8), 64'd1);
        check("s1_sum",   64'(sum8),       64'h80);
        check("s1_ovf",   64'(overflow8),  64'd1);
        check("s1_carry", 64'(carry_out8), 64'd0);
        @(posedge clk);
        #1;
        a8        = 8'h00;
        b8        = 8'h01;
        sub8      = 1'b1;
        in_valid8 = 1'b1;
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        @(negedge clk);
        check("s1b_valid", 64'(out_valid8), 64'd1);
        check("s1b_sum",   64'(sum8),       64'hFF);
        check("s1b_ovf",   64'(overflow8),  64'd0);
        check("s1b_carry", 64'(carry_out8), 64'd0);
        @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
